// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter sequencer: FSM state encoding,
// counter widths and the left-aligned letter ROM (S..Z).
package morse_pkg;

    localparam int unsigned MAX_LEN = 13;   // longest pattern (Y), also shift register width
    localparam int unsigned CNT_W   = 4;    // symbol counter width
    localparam int unsigned DIV_W   = 27;   // rate divider width
    localparam int unsigned SEL_W   = 3;    // letter select width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;  // first symbol at MSB
        logic [CNT_W-1:0]   len;      // symbols in pattern
    } rom_entry_t;

    // Letter ROM: dot=1, dash=111, intra-letter gap=0, left-aligned.
    function automatic rom_entry_t rom_lookup(input logic [SEL_W-1:0] sel);
        rom_entry_t e;
        e = '0;
        case (sel)
            3'd0: e = '{pattern: 13'b1010100000000, len: 4'd5};   // S
            3'd1: e = '{pattern: 13'b1110000000000, len: 4'd3};   // T
            3'd2: e = '{pattern: 13'b1010111000000, len: 4'd7};   // U
            3'd3: e = '{pattern: 13'b1010101110000, len: 4'd9};   // V
            3'd4: e = '{pattern: 13'b1011101110000, len: 4'd9};   // W
            3'd5: e = '{pattern: 13'b1110101011100, len: 4'd11};  // X
            3'd6: e = '{pattern: 13'b1110101110111, len: 4'd13};  // Y
            3'd7: e = '{pattern: 13'b1110111010100, len: 4'd11};  // Z
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/morse_rate_div.sv
// Symbol-rate divider: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count combinationally so the FSM can act on the same edge.
// Ports: clk_i, reset_i (sync, active-high), clr_i (sync clear),
//        en_i (count enable), tick_c_o (terminal count, combinational).
module morse_rate_div
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_c_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             term_c;

    assign term_c   = (div_q == DIV_W'(TICK_DIV - 1));
    // Tick must not depend on clr_i: the FSM derives clr_i from the tick.
    assign tick_c_o = en_i && term_c;

    // Next count: clear wins, wrap at terminal count.
    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = term_c ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Morse transmit controller: latches a letter on start, shifts its pattern
// out one symbol per TICK_DIV cycles, optionally repeats after a gap.
// Ports: clk_i, reset_i (sync, active-high), start_i, letter_sel_i[2:0],
//        repeat_i, led_out_o, busy_o, done_o (all outputs registered).
module morse_letter_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 25_000_000,
    parameter int unsigned GAP_SYMBOLS = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [SEL_W-1:0] letter_sel_i,
    input  logic             repeat_i,
    output logic             led_out_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned GAP_W = (GAP_SYMBOLS < 2) ? 1 : $clog2(GAP_SYMBOLS + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [SEL_W-1:0]   letter_q, letter_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_clr_c;
    logic               div_en_c;
    logic               tick_c;
    rom_entry_t         rom_c;

    assign rom_c = rom_lookup(letter_q);

    morse_rate_div #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_div (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (div_clr_c),
        .en_i     (div_en_c),
        .tick_c_o (tick_c)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        letter_d  = letter_q;
        div_clr_c = 1'b0;
        div_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    letter_d = letter_sel_i;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d   = rom_c.pattern;
                cnt_d     = rom_c.len;
                div_clr_c = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                div_en_c = 1'b1;
                if (tick_c) begin
                    shift_d = {shift_q[MAX_LEN-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    // Last symbol period ends on this tick.
                    if (cnt_q == CNT_W'(1)) begin
                        if (repeat_i) begin
                            gap_d     = GAP_W'(GAP_SYMBOLS);
                            div_clr_c = 1'b1;
                            state_d   = ST_GAP;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_GAP: begin
                div_en_c = 1'b1;
                if (tick_c) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        state_d = repeat_i ? ST_LOAD : ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs registered from next-state values so they line up with state.
        led_d  = (state_d == ST_SEND) && shift_d[MAX_LEN-1];
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            letter_q <= '0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            letter_q <= letter_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign led_out_o = led_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
